// File: rtl/pipelined_cla_adder_if.sv
// Handshake/data bundle for pipelined_cla_adder.
// The optional ovf signal exists only when CLA_OVERFLOW_EN is defined.
// slave  : adder side (consumes operands, produces results).
// master : producer/consumer side driving the adder.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_OVERFLOW_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor built from 4-bit CLA groups.
// Each stage resolves STAGE_GROUPS groups and hands its group carry to the
// next stage, so depth/latency/capacity is L = (WIDTH/4)/STAGE_GROUPS.
// Subtraction is a + ~b + ~cin; cout is the raw carry (1 = no borrow).
// Valid/ready with full back-pressure; outputs come straight from the last
// stage registers.
// Optional feature macro: CLA_OVERFLOW_EN adds a registered signed-overflow
// output (carry into MSB xor carry out of MSB).
module pipelined_cla_adder #(
    parameter int WIDTH        = 16,
    parameter int STAGE_GROUPS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    pipelined_cla_adder_if.slave  bus
);

    localparam int NGROUPS = WIDTH / 4;
    localparam int L       = NGROUPS / STAGE_GROUPS;

    // 4-bit look-ahead group: returns {c4, c3, sum[3:0]}; c3 is kept for
    // overflow detection on the most significant group.
    function automatic logic [5:0] cla4(
        input logic [3:0] i_a,
        input logic [3:0] i_b,
        input logic       i_c0
    );
        logic [3:0] g;
        logic [3:0] p;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       c4;
        g  = i_a & i_b;
        p  = i_a ^ i_b;
        c1 = g[0] | (p[0] & i_c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & i_c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & i_c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & i_c0);
        return {c4, c3, p ^ {c3, c2, c1, i_c0}};
    endfunction

    // Stage registers (index 0 = first stage, L-1 = output stage).
    logic             r_valid [L];
    logic [WIDTH-1:0] r_a     [L];
    logic [WIDTH-1:0] r_b     [L];
    logic [WIDTH-1:0] r_sum   [L];
    logic             r_c     [L];
    logic             r_sub   [L];

    // Per-stage sources and next values.
    logic [WIDTH-1:0] w_a_src   [L];
    logic [WIDTH-1:0] w_b_src   [L];
    logic [WIDTH-1:0] w_sum_src [L];
    logic             w_c_src   [L];
    logic             w_sub_src [L];
    logic [WIDTH-1:0] w_sum_nx  [L];
    logic             w_c_nx    [L];
    logic [5:0]       w_grp;
    logic             w_chain;
    logic             w_msb_cin;

    // Handshake.
    logic             w_adv  [L];
    logic             w_take [L];
    logic             w_next_free;
    logic             w_in_ready;
    logic             w_unused;

    // Datapath: select each stage's source and resolve its CLA groups.
    always_comb begin
        w_grp     = 6'd0;
        w_chain   = 1'b0;
        w_msb_cin = 1'b0;
        // Stage 0 sources come from the bus; b and cin are inverted for sub.
        w_a_src[0]   = bus.a;
        w_b_src[0]   = bus.b ^ {WIDTH{bus.sub}};
        w_c_src[0]   = bus.cin ^ bus.sub;
        w_sub_src[0] = bus.sub;
        w_sum_src[0] = '0;
        for (int j = 1; j < L; j++) begin
            w_a_src[j]   = r_a[j-1];
            w_b_src[j]   = r_b[j-1];
            w_c_src[j]   = r_c[j-1];
            w_sub_src[j] = r_sub[j-1];
            w_sum_src[j] = r_sum[j-1];
        end
        for (int j = 0; j < L; j++) begin
            w_sum_nx[j] = w_sum_src[j];
            w_chain     = w_c_src[j];
            for (int g = 0; g < STAGE_GROUPS; g++) begin
                w_grp = cla4(w_a_src[j][(j*STAGE_GROUPS+g)*4 +: 4],
                             w_b_src[j][(j*STAGE_GROUPS+g)*4 +: 4],
                             w_chain);
                w_sum_nx[j][(j*STAGE_GROUPS+g)*4 +: 4] = w_grp[3:0];
                w_chain   = w_grp[5];
                // The last iteration overall is the MSB group.
                w_msb_cin = w_grp[4];
            end
            w_c_nx[j] = w_chain;
        end
    end

    // Ready chain: walk from the output back, a stage moves when the next
    // one is empty or moving itself.
    always_comb begin
        w_next_free = bus.out_ready;
        for (int j = L - 1; j >= 0; j--) begin
            w_adv[j]    = r_valid[j] & w_next_free;
            w_next_free = ~r_valid[j] | w_adv[j];
        end
        w_in_ready = ~r_valid[0] | w_adv[0];
    end

    // Load enables: stage 0 on an input handshake, others when upstream moves.
    always_comb begin
        w_take[0] = bus.in_valid & w_in_ready;
        for (int j = 1; j < L; j++) begin
            w_take[j] = w_adv[j-1];
        end
    end

    // Pipeline registers with synchronous reset; data only loads on transfer.
    always_ff @(posedge clk) begin
        for (int j = 0; j < L; j++) begin
            if (rst) begin
                r_valid[j] <= 1'b0;
                r_a[j]     <= '0;
                r_b[j]     <= '0;
                r_sum[j]   <= '0;
                r_c[j]     <= 1'b0;
                r_sub[j]   <= 1'b0;
            end else if (w_take[j]) begin
                r_valid[j] <= 1'b1;
                r_a[j]     <= w_a_src[j];
                r_b[j]     <= w_b_src[j];
                r_sum[j]   <= w_sum_nx[j];
                r_c[j]     <= w_c_nx[j];
                r_sub[j]   <= w_sub_src[j];
            end else if (w_adv[j]) begin
                r_valid[j] <= 1'b0;
            end else begin
                r_valid[j] <= r_valid[j];
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid[L-1];
    assign bus.sum       = r_sum[L-1];
    assign bus.cout      = r_c[L-1];

`ifdef CLA_OVERFLOW_EN
    logic r_ovf;

    // Overflow flag travels with the output stage and holds under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_take[L-1]) begin
            r_ovf <= w_msb_cin ^ w_c_nx[L-1];
        end else begin
            r_ovf <= r_ovf;
        end
    end

    assign bus.ovf = r_ovf;
`endif

    // Sink for state that is carried for completeness but not consumed
    // (operands of the last stage, consumed low bits, the sub tag).
    always_comb begin
        w_unused = w_msb_cin;
        for (int j = 0; j < L; j++) begin
            w_unused = w_unused ^ (^r_a[j]) ^ (^r_b[j]) ^ r_sub[j];
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed self-checking bench for pipelined_cla_adder.
// dut16: WIDTH=16, STAGE_GROUPS=1 (L=4); dut32: WIDTH=32, STAGE_GROUPS=2 (L=4).
// ovf checks are compiled in when CLA_OVERFLOW_EN is defined.
module tb_pipelined_cla_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(16)) bus16 ();
    pipelined_cla_adder_if #(.WIDTH(32)) bus32 ();

    pipelined_cla_adder #(.WIDTH(16), .STAGE_GROUPS(1)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    pipelined_cla_adder #(.WIDTH(32), .STAGE_GROUPS(2)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated operation on the 16-bit instance with latency check.
    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input logic [15:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
        int lat;
        @(negedge clk);
        bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub;
        bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
        #1;
        check_val($sformatf("%s_in_ready", tag), bus16.in_ready, 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus16.in_valid = 1'b0;
        lat = 1;
        while (!bus16.out_valid && lat < 20) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        check_val($sformatf("%s_latency", tag), 64'(lat), 64'd4);
        check_val($sformatf("%s_sum", tag), bus16.sum, 64'(exp_sum));
        check_val($sformatf("%s_cout", tag), bus16.cout, 64'(exp_cout));
`ifdef CLA_OVERFLOW_EN
        check_val($sformatf("%s_ovf", tag), bus16.ovf, 64'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("note: unexpected ovf");
`endif
        @(posedge clk); @(negedge clk);
        check_val($sformatf("%s_valid_drop", tag), bus16.out_valid, 64'd0);
    endtask

    // One isolated operation on the 32-bit, two-groups-per-stage instance.
    task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [31:0] exp_sum,
                        input logic exp_cout);
        int lat;
        @(negedge clk);
        bus32.a = a; bus32.b = b; bus32.cin = cin; bus32.sub = sub;
        bus32.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        lat = 1;
        while (!bus32.out_valid && lat < 20) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        check_val($sformatf("%s_latency", tag), 64'(lat), 64'd4);
        check_val($sformatf("%s_sum", tag), bus32.sum, 64'(exp_sum));
        check_val($sformatf("%s_cout", tag), bus32.cout, 64'(exp_cout));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  sent;
        int  got;
        int  cyc;
        int  seen;
        logic rdy;
        logic pop;

        rst = 1'b1;
        bus16.in_valid = 1'b0; bus16.a = 16'd0; bus16.b = 16'd0;
        bus16.cin = 1'b0; bus16.sub = 1'b0; bus16.out_ready = 1'b0;
        bus32.in_valid = 1'b0; bus32.a = 32'd0; bus32.b = 32'd0;
        bus32.cin = 1'b0; bus32.sub = 1'b0; bus32.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_out_valid", bus16.out_valid, 64'd0);
        check_val("rst_sum", bus16.sum, 64'd0);
        check_val("rst_cout", bus16.cout, 64'd0);
        check_val("rst_in_ready", bus16.in_ready, 64'd1);
`ifdef CLA_OVERFLOW_EN
        check_val("rst_ovf", bus16.ovf, 64'd0);
`endif

        // Directed vectors, hand-computed.
        op16("add_1_1",     16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        op16("add_ffff_1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16("add_ffff_c",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16("sub_5_7",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op16("sub_5_7_b",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
        op16("sub_9_4",     16'h0009, 16'h0004, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0);
        op16("ovf_add",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op16("ovf_sub",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        op16("add_3_4",     16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

        op32("w_ffffffff_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        op32("w_add_mix",    32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0);
        op32("w_sub_0_1",    32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        op32("w_msb_carry",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        op32("w_mid_cin",    32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0);
        op32("w_stage_cross",32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h1000_0000, 1'b0);

        // Back-pressure: six back-to-back adds with the output stalled.
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus16.out_ready = 1'b0;
            bus16.in_valid  = 1'b1;
            bus16.a = 16'(sent + 1); bus16.b = 16'(sent + 1);
            bus16.cin = 1'b0; bus16.sub = 1'b0;
            #1;
            if (bus16.out_valid) check_val("stall_sum", bus16.sum, 64'h2);
            rdy = bus16.in_ready;
            @(posedge clk);
            if (rdy) sent++;
        end
        @(negedge clk);
        #1;
        check_val("full_accepts", 64'(sent), 64'd4);
        check_val("full_in_ready", bus16.in_ready, 64'd0);
        check_val("full_out_valid", bus16.out_valid, 64'd1);
        check_val("full_sum_hold", bus16.sum, 64'h2);

        // Release: results must drain in order, one per cycle.
        got = 0;
        cyc = 0;
        while (got < 6 && cyc < 40) begin
            bus16.out_ready = 1'b1;
            if (sent < 6) begin
                bus16.in_valid = 1'b1;
                bus16.a = 16'(sent + 1); bus16.b = 16'(sent + 1);
            end else begin
                bus16.in_valid = 1'b0;
            end
            #1;
            rdy = bus16.in_valid & bus16.in_ready;
            pop = bus16.out_valid;
            if (pop) check_val($sformatf("order_%0d", got), bus16.sum, 64'(2 * (got + 1)));
            @(posedge clk);
            if (rdy) sent++;
            if (pop) got++;
            cyc++;
            @(negedge clk);
        end
        bus16.in_valid = 1'b0;
        check_val("drain_count", 64'(got), 64'd6);
        check_val("drain_cycles", 64'(cyc), 64'd6);

        // Reset with three operations in flight.
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
            bus16.a = 16'h0100 + 16'(k); bus16.b = 16'h0100;
            #1;
            if (bus16.out_valid) seen++;
            @(posedge clk);
        end
        @(negedge clk);
        bus16.a = 16'hAAAA; bus16.b = 16'h5555;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus16.in_valid = 1'b0;
        #1;
        check_val("midrst_out_valid", bus16.out_valid, 64'd0);
        check_val("midrst_sum", bus16.sum, 64'd0);
        check_val("midrst_cout", bus16.cout, 64'd0);
        check_val("midrst_in_ready", bus16.in_ready, 64'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (bus16.out_valid) seen++;
        end
        check_val("midrst_no_stale", 64'(seen), 64'd0);

        op16("post_rst", 16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-look-ahead adder/subtractor built from 4-bit CLA groups.
- Resolves STAGE_GROUPS groups per pipeline stage and carries the group carry forward in registers.
- Valid/ready handshake on both sides with full back-pressure.
- Sits in the datapath wherever wide add/sub must meet timing beyond a single-cycle 4-bit CLA.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- STAGE_GROUPS, 1, number of 4-bit CLA groups resolved per stage; (WIDTH/4) must be divisible by it.
- Derived: L = (WIDTH/4)/STAGE_GROUPS = pipeline depth, latency and capacity.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block accepts an operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; borrow-in for subtract.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  raw carry-out of the final group.

Behaviour:
- Arithmetic:
  - sub=0: {cout,sum} = a + b + cin.
  - sub=1: {cout,sum} = a + ~b + ~cin, i.e. a - b - cin. cout=1 means no borrow.
  - All widths are modulo 2^WIDTH.
- Group logic:
  - Each 4-bit group computes g = a&b and p = a^b, then the look-ahead carries c1..c4 from the group carry-in.
  - No ripple inside a group.
- Pipeline:
  - Stages 1..L. Stage k holds: valid bit, low k*STAGE_GROUPS*4 sum bits, carry into the next group, the still-unconsumed upper bits of a and the (possibly inverted) b, and sub.
- Transfer:
  - Input is accepted on a rising edge with in_valid & in_ready.
  - The accepting edge loads stage 1. The result reaches stage L after L edges, counting the accepting edge as edge 1.
  - sum/cout/out_valid are driven directly from stage L registers; there is no combinational path from a/b to sum.
- Handshake and stall:
  - Stage k advances when stage k+1 is empty or is itself advancing.
  - Stage L empties on out_valid & out_ready.
  - in_ready = !valid[1] | advance[1]. The ready chain is combinational from out_ready.
  - One transaction per cycle in steady state. Order is preserved and no result is dropped or duplicated.
- Stability:
  - While out_valid=1 and out_ready=0, sum and cout hold stable.
  - While out_valid=0, sum and cout hold their last value and are don't-care to consumers.
- Full condition:
  - All L valid bits set and out_ready=0 -> in_ready=0.
  - Simultaneous out accept and in accept when full is allowed (full throughput).
- Reset:
  - rst=1 at a rising edge clears all valid bits.
  - Resulting values: out_valid=0, sum=0, cout=0, in_ready=1 once rst deasserts.
  - In-flight operations are discarded, including reset asserted mid-operation. Inputs are ignored during reset.
- L=1 (e.g. WIDTH=4): single registered stage. Latency 1, capacity 1, same handshake rules.

Optional Feature:
- Macro: CLA_OVERFLOW_EN
- Defined:
  - Adds output port ovf (1 bit), carried through the pipeline alongside stage L.
  - ovf = two's-complement signed overflow of the operation as performed: carry into MSB XOR carry out of MSB.
  - Reset value 0. Held stable under stall like sum.
- Undefined: no ovf port and no overflow logic; all other behaviour identical.

Test Plan:
- Basic add, WIDTH=16, STAGE_GROUPS=1 (L=4): a=0x0001, b=0x0001, cin=0, sub=0, out_ready=1 -> sum=0x0002, cout=0, out_valid high for one cycle, 4 edges after accept.
- Full carry propagation across all groups: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0. Same with cin=1 -> sum=0xFFFD, cout=0. a=0x0009, b=0x0004, sub=1 -> sum=0x0005, cout=1.
- Back-pressure: issue 6 back-to-back adds (a=i, b=i, i=1..6) with out_ready=0 for the first 6 cycles:
  - in_ready drops after 4 accepts.
  - sum stays 0x0002 while stalled.
  - After out_ready=1, results 0x0002, 0x0004 ... 0x000C appear in order, one per cycle, none lost.
- Reset mid-operation: 3 operations in flight, assert rst for one edge -> out_valid=0, sum=0, cout=0, in_ready=1 next cycle, no stale result ever emitted.
- Parameter sweep and overflow: WIDTH=32, STAGE_GROUPS=2 (L=4) random 1000-vector check against a behavioural model. With CLA_OVERFLOW_EN, WIDTH=16: 0x7FFF+0x0001 -> sum=0x8000, ovf=1; 0x8000-0x0001 -> ovf=1; 0x0003+0x0004 -> ovf=0.
